// File: rtl/nv_nvdla_cdma_wt_sched_pkg.sv
// Shared constants and helpers for the CDMA weight read-request scheduler.
package nv_nvdla_cdma_wt_sched_pkg;

    localparam logic SRC_WT  = 1'b0;
    localparam logic SRC_WMB = 1'b1;

    localparam int DEF_ADDR_WIDTH   = 64;
    localparam int DEF_SIZE_WIDTH   = 15;
    localparam int DEF_CREDIT_MAX   = 128;
    localparam int DEF_STARVE_LIMIT = 4;

    // Width able to hold every credit value from 0 to max_credits inclusive.
    function automatic int credit_width(input int max_credits);
        return $clog2(max_credits + 1);
    endfunction

endpackage

// File: rtl/nv_nvdla_cdma_wt_sched_arb2.sv
// Two-requester strict-priority picker: req0 wins unless swap hands priority to req1.
module nv_nvdla_cdma_wt_sched_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       swap,
    input  logic       busy,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (!busy) begin
            if (req1 && (swap || !req0)) begin
                gnt = 2'b10;
            end else if (req0) begin
                gnt = 2'b01;
            end
        end
    end

endmodule

// File: rtl/nv_nvdla_cdma_wt_rd_sched.sv
// Shares the CDMA weight read-DMA request channel between the weight and WMB fetchers,
// gating grants on latency-FIFO credits and bounding WMB starvation.
module nv_nvdla_cdma_wt_rd_sched
    import nv_nvdla_cdma_wt_sched_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int SIZE_WIDTH   = DEF_SIZE_WIDTH,
    parameter int CREDIT_MAX   = DEF_CREDIT_MAX,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                                nvdla_core_clk,
    input  logic                                nvdla_core_rstn,
    input  logic                                sched_en,
    input  logic                                wt_req_valid,
    output logic                                wt_req_ready,
    input  logic [ADDR_WIDTH-1:0]               wt_req_addr,
    input  logic [SIZE_WIDTH-1:0]               wt_req_size,
    input  logic                                wmb_req_valid,
    output logic                                wmb_req_ready,
    input  logic [ADDR_WIDTH-1:0]               wmb_req_addr,
    input  logic [SIZE_WIDTH-1:0]               wmb_req_size,
    output logic                                dma_rd_req_valid,
    input  logic                                dma_rd_req_ready,
    output logic [ADDR_WIDTH-1:0]               dma_rd_req_addr,
    output logic [SIZE_WIDTH-1:0]               dma_rd_req_size,
    output logic                                dma_rd_req_src,
    input  logic                                rsp_credit_ret,
    output logic [credit_width(CREDIT_MAX)-1:0] credit_cnt
);

    localparam int CW = credit_width(CREDIT_MAX);
    localparam int KW = SIZE_WIDTH + 1;
    localparam int MW = ((KW > CW) ? KW : CW) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic                  out_full_reg,   out_full_next;
    logic [ADDR_WIDTH-1:0] addr_reg,       addr_next;
    logic [SIZE_WIDTH-1:0] size_reg,       size_next;
    logic                  src_reg,        src_next;
    logic [CW-1:0]         credit_cnt_reg, credit_cnt_next;
    logic [SW-1:0]         starve_cnt_reg, starve_cnt_next;

    logic [SIZE_WIDTH-1:0] req_size [2];
    logic [MW-1:0]         req_cost [2];
    logic [1:0]            req_fits;
    logic [1:0]            pick;
    logic [1:0]            grant_vec;
    logic                  load_ok;
    logic                  grant;
    logic [MW-1:0]         grant_cost;
    logic [MW-1:0]         credit_wide;

    assign req_size[0] = wt_req_size;
    assign req_size[1] = wmb_req_size;

    assign load_ok = !out_full_reg || dma_rd_req_ready;

    nv_nvdla_cdma_wt_sched_arb2 u_arb (
        .req0 (wt_req_valid),
        .req1 (wmb_req_valid),
        .swap (starve_cnt_reg == STARVE_MAX),
        .busy (!(sched_en && load_ok)),
        .gnt  (pick)
    );

    // Only the arbitration winner is credit-checked, so a blocked winner holds the line.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign req_cost[gi]  = MW'(req_size[gi]) + MW'(1);
            assign req_fits[gi]  = (req_cost[gi] <= MW'(credit_cnt_reg));
            assign grant_vec[gi] = pick[gi] && req_fits[gi];
        end
    endgenerate

    assign grant         = |grant_vec;
    assign wt_req_ready  = grant_vec[0];
    assign wmb_req_ready = grant_vec[1];

    assign grant_cost  = grant_vec[1] ? req_cost[1] : (grant_vec[0] ? req_cost[0] : '0);
    assign credit_wide = MW'(credit_cnt_reg) - grant_cost + MW'(rsp_credit_ret);

    always_comb begin
        out_full_next   = out_full_reg;
        addr_next       = addr_reg;
        size_next       = size_reg;
        src_next        = src_reg;
        starve_cnt_next = starve_cnt_reg;
        credit_cnt_next = credit_wide[CW-1:0];
        if (grant) begin
            out_full_next = 1'b1;
            addr_next     = grant_vec[1] ? wmb_req_addr : wt_req_addr;
            size_next     = grant_vec[1] ? wmb_req_size : wt_req_size;
            src_next      = grant_vec[1] ? SRC_WMB : SRC_WT;
            if (grant_vec[1] || !wmb_req_valid) begin
                starve_cnt_next = '0;
            end else if (starve_cnt_reg != STARVE_MAX) begin
                starve_cnt_next = starve_cnt_reg + SW'(1);
            end
        end else if (out_full_reg && dma_rd_req_ready) begin
            out_full_next = 1'b0;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            out_full_reg   <= 1'b0;
            addr_reg       <= '0;
            size_reg       <= '0;
            src_reg        <= SRC_WT;
            credit_cnt_reg <= CW'(CREDIT_MAX);
            starve_cnt_reg <= '0;
        end else begin
            out_full_reg   <= out_full_next;
            addr_reg       <= addr_next;
            size_reg       <= size_next;
            src_reg        <= src_next;
            credit_cnt_reg <= credit_cnt_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    assign dma_rd_req_valid = out_full_reg;
    assign dma_rd_req_addr  = addr_reg;
    assign dma_rd_req_size  = size_reg;
    assign dma_rd_req_src   = src_reg;
    assign credit_cnt       = credit_cnt_reg;

    // Returning more atoms than were ever reserved means the latency FIFO is out of sync.
    a_credit_overflow : assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        credit_wide <= MW'(CREDIT_MAX));
    a_wt_size_legal : assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        !(wt_req_valid && (req_cost[0] > MW'(CREDIT_MAX))));
    a_wmb_size_legal : assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        !(wmb_req_valid && (req_cost[1] > MW'(CREDIT_MAX))));

endmodule
